// File: rtl/bram_arbiter.sv
// Round-robin front end sharing one single-port byte-writable BRAM between ports A and B.
// Grants are combinational; BRAM pins are registered and read data returns two cycles after accept.
module bram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_req,
    input  logic [3:0]        a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_addr,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic            PORT_A    = 1'b0;
    localparam logic            PORT_B    = 1'b1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic             ptr_q, ptr_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             acc_s;
    logic             sel_b_s;
    logic             ptr_blocked_s;
    logic [3:0]       req_we_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [31:0]      req_wdata_s;

    logic             bram_en_q, bram_en_d;
    logic [3:0]       bram_we_q, bram_we_d;
    logic [31:0]      bram_addr_q, bram_addr_d;
    logic [31:0]      bram_di_q, bram_di_d;
    logic             tag_rd_q, tag_rd_d;
    logic             tag_port_q, tag_port_d;

    logic             a_rvalid_q, a_rvalid_d;
    logic             b_rvalid_q, b_rvalid_d;
    logic [31:0]      a_hold_q, a_hold_d;
    logic [31:0]      b_hold_q, b_hold_d;

    // Arbitration: a lone requester always wins; on a tie the pointer decides unless its port hit the burst cap.
    always_comb begin
        ptr_blocked_s = (ptr_q == last_q) && (cnt_q >= BURST_MAX);
        if (a_req && b_req) begin
            acc_s   = 1'b1;
            sel_b_s = (ptr_q == PORT_B) ? ~ptr_blocked_s : ptr_blocked_s;
        end else if (a_req) begin
            acc_s   = 1'b1;
            sel_b_s = PORT_A;
        end else if (b_req) begin
            acc_s   = 1'b1;
            sel_b_s = PORT_B;
        end else begin
            acc_s   = 1'b0;
            sel_b_s = PORT_A;
        end
    end

    assign a_gnt = acc_s & ~sel_b_s;
    assign b_gnt = acc_s &  sel_b_s;

    // Round-robin pointer and burst counter; cnt_q == 0 means nothing granted since reset.
    always_comb begin
        ptr_d  = ptr_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (acc_s) begin
            ptr_d  = ~sel_b_s;
            last_d = sel_b_s;
            if ((cnt_q != {CNT_W{1'b0}}) && (sel_b_s == last_q)) begin
                cnt_d = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Request mux and BRAM issue stage; address and data hold when idle.
    always_comb begin
        req_we_s    = sel_b_s ? b_we    : a_we;
        req_addr_s  = sel_b_s ? b_addr  : a_addr;
        req_wdata_s = sel_b_s ? b_wdata : a_wdata;
        bram_en_d   = acc_s;
        tag_rd_d    = acc_s && (req_we_s == 4'b0000);
        tag_port_d  = sel_b_s;
        if (acc_s) begin
            bram_we_d   = req_we_s;
            bram_addr_d = 32'(req_addr_s);
            bram_di_d   = req_wdata_s;
        end else begin
            bram_we_d   = 4'b0000;
            bram_addr_d = bram_addr_q;
            bram_di_d   = bram_di_q;
        end
    end

    // Return stage: rvalid follows the issue tag; rdata tracks bram_do only while rvalid is high.
    always_comb begin
        a_rvalid_d = tag_rd_q && (tag_port_q == PORT_A);
        b_rvalid_d = tag_rd_q && (tag_port_q == PORT_B);
        a_hold_d   = a_rvalid_q ? bram_do : a_hold_q;
        b_hold_d   = b_rvalid_q ? bram_do : b_hold_q;
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q       <= PORT_A;
            last_q      <= PORT_A;
            cnt_q       <= {CNT_W{1'b0}};
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'b0000;
            bram_addr_q <= 32'h0000_0000;
            bram_di_q   <= 32'h0000_0000;
            tag_rd_q    <= 1'b0;
            tag_port_q  <= PORT_A;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_hold_q    <= 32'h0000_0000;
            b_hold_q    <= 32'h0000_0000;
        end else begin
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_di_q   <= bram_di_d;
            tag_rd_q    <= tag_rd_d;
            tag_port_q  <= tag_port_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_hold_q    <= a_hold_d;
            b_hold_q    <= b_hold_d;
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_di   = bram_di_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rvalid_q ? bram_do : a_hold_q;
    assign b_rdata   = b_rvalid_q ? bram_do : b_hold_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model with read-before-write, reference memory scoreboard,
// table-driven arbitration vectors and hand-written reset / read-after-write sequences.
module tb_bram_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_req, b_req, a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [3:0]  a_we, b_we, bram_we;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        bram_en;
    logic [31:0] bram_addr, bram_di, bram_do;

    always #5 CLK = ~CLK;

    bram_arbiter #(.ADDR_W(12), .MAX_BURST(4)) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_di(bram_di), .bram_do(bram_do)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        ar;
        logic [3:0]  aw;
        logic [11:0] aa;
        logic        br;
        logic [3:0]  bw;
        logic [11:0] ba;
        logic        ga;
        logic        gb;
    } vec_t;
    vec_t vec[14];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // BRAM model: output registered on EN, writes land one edge later (read-before-write).
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic        bm_v = 1'b0;
    logic [11:0] bm_a = 12'h0;
    logic [3:0]  bm_we = 4'h0;
    logic [31:0] bm_d = 32'h0;
    always @(posedge CLK) begin
        if (bram_en) bram_do <= mem[bram_addr[11:0]];
        if (bm_v) mem[bm_a] <= merge(mem[bm_a], bm_we, bm_d);
        bm_v  <= bram_en && (bram_we != 4'h0);
        bm_a  <= bram_addr[11:0];
        bm_we <= bram_we;
        bm_d  <= bram_di;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference memory with the same one-cycle write commit.
    logic [31:0] rmem [0:4095] = '{default: 32'h0};
    logic        rp_v = 1'b0;
    logic [11:0] rp_a;
    logic [3:0]  rp_we;
    logic [31:0] rp_d;

    logic        pv_en = 1'b0;
    logic [3:0]  pv_we = 4'h0;
    logic [31:0] hold_addr = 32'h0, hold_di = 32'h0;
    logic [31:0] last_a = 32'h0, last_b = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic port, input logic [31:0] data);
        sb_t e;
        if (sbq.size() == 0) begin
            chk($sformatf("rvalid_unexpected_port%0d", port), 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("rv_port", 32'(port), 32'(e.port));
            chk("rv_data", data, e.data);
            chk("rv_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Output monitor on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
            chk("rvalid_onehot", 32'(a_rvalid & b_rvalid), 32'd0);
            if (a_rvalid) begin
                sb_pop(1'b0, a_rdata);
                last_a = a_rdata;
            end else begin
                chk("a_rdata_hold", a_rdata, last_a);
            end
            if (b_rvalid) begin
                sb_pop(1'b1, b_rdata);
                last_b = b_rdata;
            end else begin
                chk("b_rdata_hold", b_rdata, last_b);
            end
        end
    end

    // One cycle: drive at posedge+1, check pipeline and sample grants at posedge+4.
    task automatic step(input logic ar, input logic [3:0] aw, input logic [11:0] aa,
                        input logic [31:0] ad, input logic br, input logic [3:0] bw,
                        input logic [11:0] ba, input logic [31:0] bd,
                        output logic ga, output logic gb);
        logic        acc;
        logic [3:0]  w;
        logic [11:0] ax;
        logic [31:0] d;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #3;
        chk("bram_en", 32'(bram_en), 32'(pv_en));
        chk("bram_we", 32'(bram_we), pv_en ? 32'(pv_we) : 32'd0);
        chk("bram_addr", bram_addr, hold_addr);
        chk("bram_di", bram_di, hold_di);
        ga  = a_gnt;
        gb  = b_gnt;
        acc = (ar & ga) | (br & gb);
        w   = gb ? bw : aw;
        ax  = gb ? ba : aa;
        d   = gb ? bd : ad;
        if (acc && w == 4'h0) sbq.push_back('{gb, rmem[ax], cyc + 2});
        if (rp_v) rmem[rp_a] = merge(rmem[rp_a], rp_we, rp_d);
        rp_v = acc && (w != 4'h0); rp_a = ax; rp_we = w; rp_d = d;
        pv_en = acc;
        pv_we = w;
        if (acc) begin
            hold_addr = {20'h0, ax};
            hold_di   = d;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 4'h0, 12'h0, 32'h0, ga, gb);
    endtask

    task automatic a_op(input logic [3:0] w, input logic [11:0] ad, input logic [31:0] d);
        logic ga, gb;
        step(1'b1, w, ad, d, 1'b0, 4'h0, 12'h0, 32'h0, ga, gb);
        chk("a_only_gnt", 32'({gb, ga}), 32'd1);
    endtask

    task automatic b_op(input logic [3:0] w, input logic [11:0] ad, input logic [31:0] d);
        logic ga, gb;
        step(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, w, ad, d, ga, gb);
        chk("b_only_gnt", 32'({gb, ga}), 32'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        chk({tag, "_bram_we"}, 32'(bram_we), 32'd0);
        chk({tag, "_bram_addr"}, bram_addr, 32'd0);
        chk({tag, "_bram_di"}, bram_di, 32'd0);
        chk({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
        chk({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
        chk({tag, "_a_rdata"}, a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, b_rdata, 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; in-flight reads are expected to vanish.
    task automatic do_reset(input string tag);
        a_req = 1'b0; b_req = 1'b0;
        RST = 1'b1;
        #1;
        chk_reset_outputs(tag);
        sbq.delete();
        last_a = 32'h0; last_b = 32'h0;
        pv_en = 1'b0; hold_addr = 32'h0; hold_di = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    function automatic vec_t mk(input logic ar, input logic [3:0] aw, input logic [11:0] aa,
                                input logic br, input logic [3:0] bw, input logic [11:0] ba,
                                input logic ga, input logic gb);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.br = br; v.bw = bw; v.ba = ba; v.ga = ga; v.gb = gb;
        return v;
    endfunction

    initial begin
        logic ga, gb, got_a;
        // Arbitration table; pointer starts at B with A as last grantee.
        vec[0]  = mk(1'b1, 4'h0, 12'd16, 1'b1, 4'h0, 12'd17, 1'b0, 1'b1);
        vec[1]  = mk(1'b1, 4'h0, 12'd18, 1'b1, 4'h0, 12'd19, 1'b1, 1'b0);
        vec[2]  = mk(1'b1, 4'h0, 12'd20, 1'b1, 4'h0, 12'd21, 1'b0, 1'b1);
        vec[3]  = mk(1'b1, 4'h0, 12'd5,  1'b1, 4'h0, 12'd7,  1'b1, 1'b0);
        vec[4]  = mk(1'b1, 4'h0, 12'd17, 1'b1, 4'h0, 12'd16, 1'b0, 1'b1);
        vec[5]  = mk(1'b1, 4'h0, 12'd19, 1'b1, 4'h0, 12'd18, 1'b1, 1'b0);
        vec[6]  = mk(1'b1, 4'h0, 12'd21, 1'b1, 4'h0, 12'd20, 1'b0, 1'b1);
        vec[7]  = mk(1'b1, 4'h0, 12'd7,  1'b1, 4'h0, 12'd5,  1'b1, 1'b0);
        vec[8]  = mk(1'b0, 4'h0, 12'd0,  1'b0, 4'h0, 12'd0,  1'b0, 1'b0);
        vec[9]  = mk(1'b0, 4'h0, 12'd0,  1'b1, 4'h0, 12'd16, 1'b0, 1'b1);
        vec[10] = mk(1'b0, 4'h0, 12'd0,  1'b1, 4'h0, 12'd17, 1'b0, 1'b1);
        vec[11] = mk(1'b1, 4'hF, 12'd30, 1'b0, 4'h0, 12'd0,  1'b1, 1'b0);
        vec[12] = mk(1'b1, 4'h0, 12'd18, 1'b1, 4'h0, 12'd19, 1'b0, 1'b1);
        vec[13] = mk(1'b1, 4'hF, 12'd31, 1'b1, 4'h0, 12'd30, 1'b1, 1'b0);

        RST = 1'b0;
        a_req = 1'b0; a_we = 4'h0; a_addr = 12'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 4'h0; b_addr = 12'h0; b_wdata = 32'h0;
        #1 RST = 1'b1;
        #1;
        chk_reset_outputs("por");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Write then read back through port A.
        a_op(4'hF, 12'd5, 32'hDEADBEEF);
        idle(1);
        a_op(4'h0, 12'd5, 32'h0);
        idle(3);
        chk("t1_rdata", a_rdata, 32'hDEADBEEF);

        // Byte strobe merge.
        a_op(4'hF, 12'd7, 32'h11223344);
        a_op(4'b0010, 12'd7, 32'h0000AA00);
        idle(1);
        a_op(4'h0, 12'd7, 32'h0);
        idle(3);
        chk("t2_rdata", a_rdata, 32'h1122AA44);

        // B runs six grants alone, then A must win the next tie.
        for (int i = 0; i < 6; i++) b_op(4'hF, 12'(16 + i), 32'hB0B00000 | 32'(16 + i));
        step(1'b1, 4'h0, 12'd16, 32'h0, 1'b1, 4'h0, 12'd17, 32'h0, ga, gb);
        chk("t4_a_after_b_run", 32'({gb, ga}), 32'd1);

        for (int i = 0; i < 14; i++) begin
            step(vec[i].ar, vec[i].aw, vec[i].aa, 32'hC0DE0000 | 32'(vec[i].aa),
                 vec[i].br, vec[i].bw, vec[i].ba, 32'hB0B00000 | 32'(vec[i].ba), ga, gb);
            chk($sformatf("tbl%0d_gnt", i), 32'({gb, ga}), 32'({vec[i].gb, vec[i].ga}));
        end
        idle(3);

        // B starts a run, then A joins: A must be granted within MAX_BURST cycles.
        for (int i = 0; i < 3; i++) b_op(4'h0, 12'(16 + i), 32'h0);
        got_a = 1'b0;
        for (int i = 0; i < 4 && !got_a; i++) begin
            step(1'b1, 4'h0, 12'd30, 32'h0, 1'b1, 4'h0, 12'd31, 32'h0, ga, gb);
            got_a = ga;
        end
        chk("t4_a_within_burst", 32'(got_a), 32'd1);
        idle(3);

        // Same-address write then read in consecutive cycles returns the old word.
        a_op(4'hF, 12'd40, 32'h00001234);
        idle(1);
        a_op(4'hF, 12'd40, 32'h00005555);
        a_op(4'h0, 12'd40, 32'h0);
        idle(3);
        chk("t5_raw_old", a_rdata, 32'h00001234);
        a_op(4'h0, 12'd40, 32'h0);
        idle(3);
        chk("t5_later_new", a_rdata, 32'h00005555);

        // Reset one cycle after a read accept.
        a_op(4'h0, 12'd5, 32'h0);
        do_reset("rst");
        step(1'b1, 4'h0, 12'd7, 32'h0, 1'b1, 4'h0, 12'd5, 32'h0, ga, gb);
        chk("t6_first_tie_a", 32'({gb, ga}), 32'd1);
        idle(4);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
